// File: rtl/wlfsr_seq_pkg.sv
// rtl/wlfsr_seq_pkg.sv - shared types and constants for the weight LFSR sequencer
package wlfsr_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_COMPUTE,
        S_DONE
    } seq_state_e;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_COMPUTE = 2'd2;

    localparam int ROWS_DEF   = 486;
    localparam int ADDR_W_DEF = $clog2(ROWS_DEF);

endpackage

// File: rtl/weight_lfsr_sequencer_if.sv
// rtl/weight_lfsr_sequencer_if.sv - command and seed-stream handshake bundle
interface weight_lfsr_sequencer_if #(
    parameter int ARG_W = 16,
    parameter int N_L   = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [ARG_W-1:0] cmd_arg;
    logic             cmd_opt;
    logic             seed_valid;
    logic             seed_ready;
    logic [N_L-1:0]   seed_data;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_opt, seed_valid, seed_data,
        input  cmd_ready, seed_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_opt, seed_valid, seed_data,
        output cmd_ready, seed_ready
    );
endinterface

// File: rtl/wlfsr_seq_counter.sv
// rtl/wlfsr_seq_counter.sv - loadable up/down counter with terminal-value flag
module wlfsr_seq_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] count,
    output logic         term
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

    assign term = (count == term_val);

endmodule

// File: rtl/weight_lfsr_sequencer.sv
// rtl/weight_lfsr_sequencer.sv - command-driven control of the weight LFSR bank (option: WLFSR_SEQ_STAT_EN)
module weight_lfsr_sequencer
    import wlfsr_seq_pkg::*;
#(
    parameter int N_L_REG = 16,
    parameter int N_L     = 16,
    parameter int ROWS    = ROWS_DEF,
    parameter int ARG_W   = 16,
    localparam int SEL_W  = $clog2(N_L_REG),
    localparam int ADDR_W = $clog2(ROWS)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    weight_lfsr_sequencer_if.slave bus,
    input  logic                 abort,
    output logic                 done,
    output logic                 err,
    output logic                 lfsr_load,
    output logic                 lfsr_en,
    output logic                 read_en,
    output logic                 compute_en,
    output logic                 lfsr_option_sel,
    output logic [SEL_W-1:0]     lfsr_sel,
    output logic [N_L-1:0]       LFSR_REG_INIT,
    output logic [ADDR_W-1:0]    READ_ADDR
`ifdef WLFSR_SEQ_STAT_EN
    ,
    output logic [31:0]          stat_lfsr_cycles
`endif
);

    seq_state_e state, state_n;

    logic cmd_ready_q, seed_ready_q;
    logic cmd_ready_n, seed_ready_n;
    logic err_n, lfsr_load_n, read_en_n, compute_en_n, opt_n;
    logic [SEL_W-1:0] sel_n;
    logic [N_L-1:0]   init_n;

    logic idx_load, idx_en, row_load, row_en, burst_load, burst_en;
    logic [SEL_W-1:0] idx_count;
    logic [ARG_W-1:0] burst_count;
    logic idx_term, row_term, burst_term;

    logic cmd_hs, seed_hs;

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.seed_ready = seed_ready_q;
    assign cmd_hs  = bus.cmd_valid & cmd_ready_q;
    assign seed_hs = bus.seed_valid & seed_ready_q;

    wlfsr_seq_counter #(.W(SEL_W)) u_idx_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (idx_load),
        .load_val ('0),
        .en       (idx_en),
        .up       (1'b1),
        .term_val (SEL_W'(N_L_REG - 1)),
        .count    (idx_count),
        .term     (idx_term)
    );

    wlfsr_seq_counter #(.W(ADDR_W)) u_row_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (row_load),
        .load_val (bus.cmd_arg[ADDR_W-1:0]),
        .en       (row_en),
        .up       (1'b1),
        .term_val (ADDR_W'(ROWS - 1)),
        .count    (READ_ADDR),
        .term     (row_term)
    );

    wlfsr_seq_counter #(.W(ARG_W)) u_burst_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (burst_load),
        .load_val (bus.cmd_arg),
        .en       (burst_en),
        .up       (1'b0),
        .term_val (ARG_W'(1)),
        .count    (burst_count),
        .term     (burst_term)
    );

    always_comb begin
        state_n      = state;
        seed_ready_n = 1'b0;
        err_n        = 1'b0;
        lfsr_load_n  = 1'b0;
        read_en_n    = 1'b0;
        compute_en_n = 1'b0;
        opt_n        = lfsr_option_sel;
        sel_n        = lfsr_sel;
        init_n       = LFSR_REG_INIT;
        idx_load     = 1'b0;
        idx_en       = 1'b0;
        row_load     = 1'b0;
        row_en       = 1'b0;
        burst_load   = 1'b0;
        burst_en     = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_hs) begin
                    opt_n = bus.cmd_opt;
                    case (bus.cmd_op)
                        OP_LOAD: begin
                            state_n      = S_LOAD;
                            idx_load     = 1'b1;
                            seed_ready_n = 1'b1;
                        end
                        OP_READ: begin
                            if (bus.cmd_arg < ARG_W'(ROWS)) begin
                                state_n   = S_READ;
                                row_load  = 1'b1;
                                read_en_n = 1'b1;
                            end else begin
                                state_n = S_DONE;
                                err_n   = 1'b1;
                            end
                        end
                        OP_COMPUTE: begin
                            if (bus.cmd_arg != '0) begin
                                state_n      = S_COMPUTE;
                                burst_load   = 1'b1;
                                compute_en_n = 1'b1;
                            end else begin
                                state_n = S_DONE;
                            end
                        end
                        default: begin
                            state_n = S_DONE;
                            err_n   = 1'b1;
                        end
                    endcase
                end
            end
            S_LOAD: begin
                // The last seed's lfsr_load pulse is still issued in LOAD so DONE sees no strobes.
                if (abort) begin
                    state_n = S_IDLE;
                end else if (lfsr_load && lfsr_sel == SEL_W'(N_L_REG - 1)) begin
                    state_n = S_DONE;
                end else begin
                    seed_ready_n = !(seed_hs && idx_term);
                    if (seed_hs) begin
                        lfsr_load_n = 1'b1;
                        sel_n       = idx_count;
                        init_n      = bus.seed_data;
                        idx_en      = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (row_term) begin
                    state_n = S_DONE;
                end else begin
                    read_en_n = 1'b1;
                    row_en    = 1'b1;
                end
            end
            S_COMPUTE: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (burst_term || burst_count == '0) begin
                    state_n = S_DONE;
                end else begin
                    compute_en_n = 1'b1;
                    burst_en     = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        cmd_ready_n = (state_n == S_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= S_IDLE;
            cmd_ready_q     <= 1'b0;
            seed_ready_q    <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            lfsr_load       <= 1'b0;
            lfsr_en         <= 1'b0;
            read_en         <= 1'b0;
            compute_en      <= 1'b0;
            lfsr_option_sel <= 1'b0;
            lfsr_sel        <= '0;
            LFSR_REG_INIT   <= '0;
        end else begin
            state           <= state_n;
            cmd_ready_q     <= cmd_ready_n;
            seed_ready_q    <= seed_ready_n;
            done            <= (state_n == S_DONE);
            err             <= err_n;
            lfsr_load       <= lfsr_load_n;
            lfsr_en         <= compute_en_n;
            read_en         <= read_en_n;
            compute_en      <= compute_en_n;
            lfsr_option_sel <= opt_n;
            lfsr_sel        <= sel_n;
            LFSR_REG_INIT   <= init_n;
        end
    end

`ifdef WLFSR_SEQ_STAT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stat_lfsr_cycles <= '0;
        end else if (lfsr_en && stat_lfsr_cycles != 32'hFFFF_FFFF) begin
            stat_lfsr_cycles <= stat_lfsr_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_lfsr_sequencer.sv
// tb/tb_weight_lfsr_sequencer.sv - scoreboard bench for weight_lfsr_sequencer (option: WLFSR_SEQ_STAT_EN)
module tb_weight_lfsr_sequencer;
    import wlfsr_seq_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    logic abort;
    logic done, err, lfsr_load, lfsr_en, read_en, compute_en, lfsr_option_sel;
    logic [3:0]  lfsr_sel;
    logic [15:0] LFSR_REG_INIT;
    logic [8:0]  READ_ADDR;
`ifdef WLFSR_SEQ_STAT_EN
    logic [31:0] stat_lfsr_cycles;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    weight_lfsr_sequencer_if #(.ARG_W(16), .N_L(16)) bus ();

    weight_lfsr_sequencer dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .bus             (bus),
        .abort           (abort),
        .done            (done),
        .err             (err),
        .lfsr_load       (lfsr_load),
        .lfsr_en         (lfsr_en),
        .read_en         (read_en),
        .compute_en      (compute_en),
        .lfsr_option_sel (lfsr_option_sel),
        .lfsr_sel        (lfsr_sel),
        .LFSR_REG_INIT   (LFSR_REG_INIT),
        .READ_ADDR       (READ_ADDR)
`ifdef WLFSR_SEQ_STAT_EN
        ,
        .stat_lfsr_cycles(stat_lfsr_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Event word: {kind, x, y}; 1=load{sel,init} 2=read{addr} 3=compute{lfsr_en,opt} 4=done{err}
    function automatic logic [31:0] ev(input logic [3:0] k, input logic [11:0] x, input logic [15:0] y);
        return {k, x, y};
    endfunction

    always @(negedge CLK) begin
        logic [31:0] got;
        logic        have;
        if (RESET === 1'b0) begin
            have = 1'b1;
            got  = '0;
            if (lfsr_load)       got = ev(4'd1, {8'd0, lfsr_sel}, LFSR_REG_INIT);
            else if (read_en)    got = ev(4'd2, {3'd0, READ_ADDR}, 16'd0);
            else if (compute_en) got = ev(4'd3, {11'd0, lfsr_en}, {15'd0, lfsr_option_sel});
            else if (done)       got = ev(4'd4, {11'd0, err}, 16'd0);
            else                 have = 1'b0;
            if (read_en || compute_en) check("rd_cmp_exclusive", read_en & compute_en, 0);
            if (lfsr_load || lfsr_en)  check("load_en_exclusive", lfsr_load & lfsr_en, 0);
            if (have) begin
                if (exp_q.size() == 0) check("unexpected_event", {32'd0, got}, 64'd0);
                else check("event", {32'd0, got}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [15:0] arg, input logic opt);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.cmd_opt   = opt;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("cmd_accept_timeout", n < 100, 1);
        @(posedge CLK);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!done && n < budget);
        check("done_seen", done, 1);
    endtask

    task automatic drain();
        @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        RESET = 1'b1;
        abort = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'd0;
        bus.cmd_arg    = 16'd0;
        bus.cmd_opt    = 1'b0;
        bus.seed_valid = 1'b0;
        bus.seed_data  = 16'd0;

        repeat (3) @(negedge CLK);
        check("reset_outputs", {bus.cmd_ready, bus.seed_ready, done, err, lfsr_load, lfsr_en, read_en,
              compute_en, lfsr_option_sel, lfsr_sel, LFSR_REG_INIT, READ_ADDR}, 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("cmd_ready_after_reset", bus.cmd_ready, 1);

        // LOAD 16 seeds with seed_valid toggling every other cycle
        for (int i = 0; i < 16; i++) exp_q.push_back(ev(4'd1, 12'(i), 16'(i + 1)));
        exp_q.push_back(ev(4'd4, 12'd0, 16'd0));
        issue(OP_LOAD, 16'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            int k = 0;
            @(negedge CLK);
            bus.seed_valid = 1'b1;
            bus.seed_data  = 16'(i + 1);
            while (!bus.seed_ready && k < 50) begin
                @(negedge CLK);
                k++;
            end
            check("seed_ready_timeout", k < 50, 1);
            @(posedge CLK);
            #1 bus.seed_valid = 1'b0;
        end
        wait_done(20, n);
        drain();

        // READ near the top of the decoder
        for (int r = 480; r < 486; r++) exp_q.push_back(ev(4'd2, 12'(r), 16'd0));
        exp_q.push_back(ev(4'd4, 12'd0, 16'd0));
        issue(OP_READ, 16'd480, 1'b0);
        wait_done(20, n);
        check("read480_latency", n, 7);
        drain();

        // READ start out of range
        exp_q.push_back(ev(4'd4, 12'd1, 16'd0));
        issue(OP_READ, 16'd486, 1'b0);
        @(negedge CLK);
        check("read486_done_next", {done, err}, 2'b11);
        drain();

        // COMPUTE 5 with option set
        for (int c = 0; c < 5; c++) exp_q.push_back(ev(4'd3, 12'd1, 16'd1));
        exp_q.push_back(ev(4'd4, 12'd0, 16'd0));
        issue(OP_COMPUTE, 16'd5, 1'b1);
        wait_done(20, n);
        check("compute5_latency", n, 6);
        drain();

        // COMPUTE 0
        exp_q.push_back(ev(4'd4, 12'd0, 16'd0));
        issue(OP_COMPUTE, 16'd0, 1'b0);
        wait_done(5, n);
        check("compute0_latency", n, 1);
        drain();

        // abort in the 3rd cycle of a long burst
        for (int c = 0; c < 3; c++) exp_q.push_back(ev(4'd3, 12'd1, 16'd0));
        issue(OP_COMPUTE, 16'd100, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #1 abort = 1'b1;
        @(posedge CLK);
        #1 abort = 1'b0;
        @(negedge CLK);
        check("abort_strobes", {compute_en, lfsr_en, done}, 3'b000);
        check("abort_cmd_ready", bus.cmd_ready, 1);
        repeat (3) @(negedge CLK);
        check("abort_queue", exp_q.size(), 0);

        // RESET in the middle of a READ sweep
        for (int r = 0; r < 486; r++) exp_q.push_back(ev(4'd2, 12'(r), 16'd0));
        exp_q.push_back(ev(4'd4, 12'd0, 16'd0));
        issue(OP_READ, 16'd0, 1'b0);
        n = 0;
        while (!(read_en && READ_ADDR == 9'd200) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("reach_row200", n < 300, 1);
        #1 RESET = 1'b1;
        #1;
        exp_q.delete();
        check("reset_midread_outputs", {bus.cmd_ready, bus.seed_ready, done, err, lfsr_load, lfsr_en,
              read_en, compute_en, lfsr_option_sel, lfsr_sel, LFSR_REG_INIT, READ_ADDR}, 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("cmd_ready_after_rereset", bus.cmd_ready, 1);

        for (int r = 0; r < 486; r++) exp_q.push_back(ev(4'd2, 12'(r), 16'd0));
        exp_q.push_back(ev(4'd4, 12'd0, 16'd0));
        issue(OP_READ, 16'd0, 1'b0);
        wait_done(600, n);
        check("read0_latency", n, 487);
        drain();

`ifdef WLFSR_SEQ_STAT_EN
        for (int c = 0; c < 5; c++) exp_q.push_back(ev(4'd3, 12'd1, 16'd0));
        exp_q.push_back(ev(4'd4, 12'd0, 16'd0));
        issue(OP_COMPUTE, 16'd5, 1'b0);
        wait_done(20, n);
        drain();
        for (int c = 0; c < 7; c++) exp_q.push_back(ev(4'd3, 12'd1, 16'd0));
        exp_q.push_back(ev(4'd4, 12'd0, 16'd0));
        issue(OP_COMPUTE, 16'd7, 1'b0);
        wait_done(20, n);
        drain();
        check("stat_lfsr_cycles", stat_lfsr_cycles, 12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_lfsr_sequencer.md
# weight_lfsr_sequencer

Command-driven controller for the 81-row weight LFSR bank with read decoder. It accepts LOAD, READ and COMPUTE commands over a valid/ready handshake, then drives the bank's control inputs cycle by cycle:
- seed loading: `lfsr_load`, `lfsr_sel`, `LFSR_REG_INIT`
- row-select sweeps: `read_en`, `READ_ADDR`
- stochastic compute bursts: `compute_en`, `lfsr_en`

It sits between the array-level scheduler and the bank, and is the only writer of the bank's control pins.

## Interface
Parameters:
- N_L_REG, 16: number of seed registers in the bank (lfsr_sel range).
- N_L, 16: seed word width.
- ROWS, 486: decoder rows (N_R*FXP = 81*6).
- ARG_W, 16: command argument width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=LOAD, 1=READ, 2=COMPUTE, 3=illegal.
- cmd_arg  in  ARG_W  READ: start row; COMPUTE: burst length in cycles; LOAD: ignored.
- cmd_opt  in  1  lfsr_option_sel value latched with the command.
- seed_valid / seed_ready  in / out  1  seed stream handshake.
- seed_data  in  N_L  seed word.
- abort  in  1  synchronous abort of the current command.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  qualifies done; set for illegal op or out-of-range READ start.
- lfsr_load, lfsr_en, read_en, compute_en, lfsr_option_sel  out  1  bank controls.
- lfsr_sel  out  $clog2(N_L_REG)  seed register index.
- LFSR_REG_INIT  out  N_L  seed value.
- READ_ADDR  out  $clog2(ROWS)  decoder row.

## Operation
States: IDLE, LOAD, READ, COMPUTE, DONE.
- IDLE: cmd_ready=1. On handshake, latch op, arg and opt.
  - LOAD goes to LOAD.
  - READ goes to READ if arg<ROWS, else to DONE with err=1.
  - COMPUTE goes to COMPUTE if arg>0, else to DONE with err=0.
  - op 3 goes to DONE with err=1.
- LOAD: seed_ready=1. Seed index idx starts at 0. Each seed handshake registers lfsr_load=1, lfsr_sel=idx, LFSR_REG_INIT=seed_data for exactly one cycle, then idx++. After the handshake with idx=N_L_REG-1, go to DONE. A stalled seed_valid keeps the state in LOAD with lfsr_load=0.
- READ: read_en=1. READ_ADDR starts at arg and increments by 1 each cycle. After the cycle with READ_ADDR=ROWS-1, go to DONE. No wrap-around.
- COMPUTE: compute_en=1 and lfsr_en=1 for exactly arg consecutive cycles, counted by a down-counter. Go to DONE when the count reaches 0.
- lfsr_option_sel holds the latched cmd_opt from acceptance until the next accepted command.
- DONE: done=1 and err as decided, for one cycle, then IDLE. All bank strobes are 0 in DONE.
- abort has priority over every transition in LOAD, READ and COMPUTE. On abort: next cycle IDLE, all strobes 0, no done pulse. abort in IDLE or DONE has no effect.
- read_en and compute_en are never high in the same cycle. lfsr_load is never high together with lfsr_en.

## Timing
- All outputs are registered.
- Reset: state=IDLE, and the following are all 0: cmd_ready, seed_ready, done, err, every bank control, lfsr_sel, LFSR_REG_INIT, READ_ADDR, counters. cmd_ready rises in the first cycle after reset release.
- Command accepted at edge t: the first bank strobe (read_en or compute_en) is high in cycle t+1.
- Seed handshake at edge t: lfsr_load is high in cycle t+1.
- READ from start s: read_en is high for ROWS-s cycles, then done the next cycle.
- COMPUTE with length n: strobes are high for n cycles, then done.
- Next command is accepted earliest one cycle after done.
- RESET asserted mid-command: outputs clear immediately (asynchronously); the command is lost with no done.

## Configuration
- WLFSR_SEQ_STAT_EN defined: adds output stat_lfsr_cycles [31:0], a count of lfsr_en-high cycles since reset.
  - Saturates at 0xFFFFFFFF.
  - Cleared by RESET only.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package wlfsr_seq_pkg holds:
  - state enum (IDLE/LOAD/READ/COMPUTE/DONE);
  - opcode constants OP_LOAD=2'd0, OP_READ=2'd1, OP_COMPUTE=2'd2;
  - ROWS default and derived address width.
- One sub-module: wlfsr_seq_counter, a loadable up/down counter with terminal flag, instantiated for the seed index, row address and burst length.

## Test plan
- Reset, then LOAD with 16 seeds 0x0001..0x0010, seed_valid toggling every other cycle. Expect 16 lfsr_load pulses with lfsr_sel 0..15 and matching LFSR_REG_INIT, then one done with err=0.
- READ arg=480. Expect read_en for 6 cycles with READ_ADDR 480..485, then done. READ arg=486: done with err=1 one cycle after acceptance, read_en never high.
- COMPUTE arg=5, cmd_opt=1. Expect compute_en=lfsr_en=1 for exactly 5 cycles, lfsr_option_sel=1, then done. COMPUTE arg=0: done next cycle, no strobes.
- abort in the 3rd cycle of COMPUTE arg=100. Expect strobes 0 next cycle, state IDLE, no done pulse, cmd_ready=1.
- RESET asserted during READ at row 200. Expect all outputs 0 immediately, then a fresh READ from 0 completing after 486 cycles.
- WLFSR_SEQ_STAT_EN: COMPUTE 5 then COMPUTE 7. Expect stat_lfsr_cycles=12.
